// File: rtl/inst_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | inst_loader_pkg: shared loader encodings and bus types                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package inst_loader_pkg;

    typedef logic [7:0]  ld_byte_t;     // LdByteBus
    typedef logic [15:0] inst_word_t;   // InstWordBus

    localparam logic [2:0] LdIdle  = 3'd0;
    localparam logic [2:0] LdLenLo = 3'd1;
    localparam logic [2:0] LdLenHi = 3'd2;
    localparam logic [2:0] LdDatLo = 3'd3;
    localparam logic [2:0] LdDatHi = 3'd4;
    localparam logic [2:0] LdChk   = 3'd5;
    localparam logic [2:0] LdDone  = 3'd6;
    localparam logic [2:0] LdErr   = 3'd7;

    // Resting states are the only ones that honour start.
    function automatic logic ld_is_rest(input logic [2:0] st);
        return (st == LdIdle) || (st == LdDone) || (st == LdErr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_loader.sv
// +----------------------------------------------------------------------------+
// | inst_loader: framed byte stream -> 16-bit instruction memory writes        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  ld_byte_t          byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output inst_word_t        mem_wdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam logic [16:0]       DepthLim = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] BaseA    = ADDR_W'(BASE_ADDR);

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    ld_byte_t          low_q, low_d;
    ld_byte_t          chk_q, chk_d;
    inst_word_t        wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;

    logic              accept;
    logic [15:0]       n_frame;
    logic [16:0]       words_inc;

    assign byte_ready = (state_q == LdLenLo) || (state_q == LdLenHi) ||
                        (state_q == LdDatLo) || (state_q == LdDatHi) ||
                        (state_q == LdChk);
    assign accept     = byte_valid && byte_ready;
    assign n_frame    = {byte_data, len_q[7:0]};
    assign words_inc  = 17'(words_q) + 17'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        low_d   = low_q;
        chk_d   = chk_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        words_d = words_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        stall_d = stall_q;

        if (abort) begin
            // Counters and status are frozen; only the control path resets.
            state_d = LdIdle;
            stall_d = 1'b0;
        end else begin
            if (we_q) begin
                words_d = words_q + 1'b1;
                waddr_d = waddr_q + 1'b1;
            end
            case (state_q)
                LdIdle, LdDone, LdErr: begin
                    if (start) begin
                        state_d = LdLenLo;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        words_d = '0;
                        chk_d   = '0;
                        len_d   = '0;
                        waddr_d = BaseA;
                        stall_d = 1'b1;
                    end
                end
                LdLenLo: begin
                    if (accept) begin
                        len_d   = {8'h00, byte_data};
                        state_d = LdLenHi;
                    end
                end
                LdLenHi: begin
                    if (accept) begin
                        len_d = n_frame;
                        if ({1'b0, n_frame} > DepthLim) begin
                            state_d = LdErr;
                            err_d   = 1'b1;
                            stall_d = 1'b0;
                        end else if (n_frame == 16'd0) begin
                            state_d = LdChk;
                        end else begin
                            state_d = LdDatLo;
                        end
                    end
                end
                LdDatLo: begin
                    if (accept) begin
                        low_d   = byte_data;
                        chk_d   = chk_q ^ byte_data;
                        state_d = LdDatHi;
                    end
                end
                LdDatHi: begin
                    if (accept) begin
                        chk_d   = chk_q ^ byte_data;
                        wdata_d = {byte_data, low_q};
                        we_d    = 1'b1;
                        // words_q already reflects every earlier word here.
                        state_d = (words_inc == {1'b0, len_q}) ? LdChk : LdDatLo;
                    end
                end
                LdChk: begin
                    if (accept) begin
                        stall_d = 1'b0;
                        if (byte_data == chk_q) begin
                            state_d = LdDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LdErr;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: state_d = LdIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LdIdle;
            len_q   <= '0;
            low_q   <= '0;
            chk_q   <= '0;
            wdata_q <= '0;
            waddr_q <= BaseA;
            words_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            low_q   <= low_d;
            chk_q   <= chk_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            words_q <= words_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_stall    = stall_q;
    assign busy         = !ld_is_rest(state_q);
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

`default_nettype wire
